pid_sp_ramp: RTL

Setpoint sequencer that drives the set-point and integrator-reset inputs of the PID controller. It accepts target setpoints over a valid/ready handshake and slews `set_sp` toward each target in rate-limited steps. It optionally issues a one-cycle integrator reset, then watches the loop's measured signal and reports when the loop has settled. It sits between the register bank or sequencing logic and the PID block, on the PID's configuration/control side.

---
 rtl/pid_pkg.sv | 14 +
 rtl/pid_sp_ramp_if.sv | 14 +
 rtl/pid_settle.sv | 42 ++++
 rtl/pid_sp_ramp.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID block and its setpoint sequencer.
package pid_pkg;

    // Data width shared by the PID input, set-point and sequencer paths.
    localparam int PID_DWI = 14;

    // Sequencer states; ST_SETTLE is only reachable with PID_SP_SETTLE_EN.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2
    } sp_state_t;

endpackage

// File: rtl/pid_sp_ramp_if.sv
// Target handshake between the register bank / sequencing logic and pid_sp_ramp.
interface pid_sp_ramp_if
    import pid_pkg::*;
#(
    parameter int DWI = PID_DWI
);
    logic signed [DWI-1:0] dat;   // target setpoint
    logic                  irst;  // request integrator reset with this target
    logic                  vld;
    logic                  rdy;

    modport master (output dat, irst, vld, input rdy);
    modport slave  (input dat, irst, vld, output rdy);
endinterface

// File: rtl/pid_settle.sv
// Settle detector: tolerance compare of set_sp against the measured loop
// input plus a saturating in-tolerance hold counter. Compiled in only with
// PID_SP_SETTLE_EN.
module pid_settle
    import pid_pkg::*;
#(
    parameter int DWI = PID_DWI,
    parameter int SW  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,        // in SETTLE and not being retargeted
    input  logic signed [DWI-1:0] set_sp,
    input  logic signed [DWI-1:0] mon_dat,
    input  logic        [DWI-1:0] cfg_tol,
    input  logic        [SW-1:0]  cfg_hold,
    output logic                  hit        // hold reached on an in-tolerance cycle
);

    logic signed [DWI:0] err;
    logic        [DWI:0] err_mag;   // unsigned, so 2^DWI fits
    logic                in_tol;
    logic        [SW-1:0] hold_cnt;

    // Error magnitude in DWI+1 bits and tolerance decision.
    always_comb begin
        err     = {set_sp[DWI-1], set_sp} - {mon_dat[DWI-1], mon_dat};
        err_mag = err[DWI] ? -err : err;
        in_tol  = (err_mag <= {1'b0, cfg_tol});
        hit     = en && in_tol && (hold_cnt == cfg_hold);
    end

    // Hold counter: counts consecutive in-tolerance cycles, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rstn || !en || !in_tol || hit) begin
            hold_cnt <= '0;
        end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pid_sp_ramp.sv
// Setpoint sequencer for the PID block: accepts targets over a valid/ready
// handshake, slews set_sp toward each target in rate-limited steps, issues an
// optional one-cycle integrator reset and reports completion on done.
// Build option: PID_SP_SETTLE_EN adds a SETTLE state that waits for the
// measured signal to stay within tolerance before done; without it, done
// pulses on the step that reaches the target.
module pid_sp_ramp
    import pid_pkg::*;
#(
    parameter int DWI = PID_DWI,
    parameter int CW  = 16,
    parameter int SW  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    pid_sp_ramp_if.slave          tgt,
    input  logic        [DWI-1:0] cfg_step,
    input  logic        [CW-1:0]  cfg_div,
    input  logic        [DWI-1:0] cfg_tol,
    input  logic        [SW-1:0]  cfg_hold,
    input  logic signed [DWI-1:0] mon_dat,
    output logic signed [DWI-1:0] set_sp,
    output logic                  int_rst,
    output logic                  busy,
    output logic                  done
);

    sp_state_t             state, state_nxt;
    logic                  done_nxt;

    logic signed [DWI-1:0] tgt_q;
    logic        [DWI-1:0] step_q;
    logic        [CW-1:0]  div_q;
    logic        [CW-1:0]  div_cnt;

    logic                  accept;
    logic                  tick;
    logic signed [DWI:0]   diff;
    logic        [DWI:0]   diff_mag;
    logic                  snap;       // this step lands exactly on the target
    logic signed [DWI-1:0] sp_nxt;

    // Handshake and status decode straight from the state register.
    assign tgt.rdy = (state != ST_RAMP);
    assign busy    = (state != ST_IDLE);
    assign accept  = tgt.vld && tgt.rdy;
    assign tick    = (state == ST_RAMP) && (div_cnt == div_q);

`ifdef PID_SP_SETTLE_EN
    logic settle_hit;

    pid_settle #(
        .DWI (DWI),
        .SW  (SW)
    ) u_settle (
        .clk      (clk),
        .rstn     (rstn),
        .en       ((state == ST_SETTLE) && !accept),
        .set_sp   (set_sp),
        .mon_dat  (mon_dat),
        .cfg_tol  (cfg_tol),
        .cfg_hold (cfg_hold),
        .hit      (settle_hit)
    );
`else
    // Monitor and settle configuration have no function in this build.
    logic unused_settle;
    assign unused_settle = ^{mon_dat, cfg_tol, cfg_hold};
`endif

    // Next rate-limited setpoint; the result always lies between set_sp and
    // the target, so the DWI-bit truncation cannot wrap.
    // NOTE: every always_comb output gets a value on every path; a missing
    // default would infer a latch.
    always_comb begin
        diff     = {tgt_q[DWI-1], tgt_q} - {set_sp[DWI-1], set_sp};
        diff_mag = diff[DWI] ? -diff : diff;
        snap     = (step_q == '0) || (diff_mag <= {1'b0, step_q});
        if (snap) begin
            sp_nxt = tgt_q;
        end else if (diff[DWI]) begin
            sp_nxt = set_sp - step_q;
        end else begin
            sp_nxt = set_sp + step_q;
        end
    end

    // Next-state and done decode.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (tick && snap) begin
`ifdef PID_SP_SETTLE_EN
                    state_nxt = ST_SETTLE;
`else
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PID_SP_SETTLE_EN
            ST_SETTLE: begin
                // A new target aborts settling without done.
                if (accept) begin
                    state_nxt = ST_RAMP;
                end else if (settle_hit) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Datapath: target latch, interval counter, setpoint and output pulses.
    // NOTE: the latched target/step/interval are reset too, so a reset
    // mid-ramp discards them instead of leaving stale values behind.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tgt_q   <= '0;
            step_q  <= '0;
            div_q   <= '0;
            div_cnt <= '0;
            set_sp  <= '0;
            int_rst <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= done_nxt;
            int_rst <= accept && tgt.irst;
            if (accept) begin
                tgt_q   <= tgt.dat;
                step_q  <= cfg_step;
                div_q   <= cfg_div;
                div_cnt <= '0;
            end else if (state == ST_RAMP) begin
                if (tick) begin
                    div_cnt <= '0;
                    set_sp  <= sp_nxt;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule
